// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types and defaults for the FIR tap sequencer: FSM state encoding
// and the default sample-rate, tap-count and coefficient geometry.
package fir_ctrl_pkg;

  localparam int unsigned NUM_TAP_DEF = 10;
  localparam int unsigned CLK_DIV_DEF = 40;
  localparam int unsigned COEFF_W_DEF = 16;
  localparam int unsigned TAP_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    ACC  = 2'd3
  } state_t;

endpackage : fir_ctrl_pkg

// File: rtl/fir_tap_sequencer_if.sv
// Host coefficient-write channel: valid/ready handshake carrying a tap index
// and a signed coefficient.
interface fir_tap_sequencer_if
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned COEFF_W = COEFF_W_DEF
) ();

  logic                        iCfgValid;
  logic                        oCfgReady;
  logic [TAP_IDX_W-1:0]        iCfgAddr;
  logic signed [COEFF_W-1:0]   iCfgData;

  modport master (
    output iCfgValid,
    output iCfgAddr,
    output iCfgData,
    input  oCfgReady
  );

  modport slave (
    input  iCfgValid,
    input  iCfgAddr,
    input  iCfgData,
    output oCfgReady
  );

endinterface : fir_tap_sequencer_if

// File: rtl/fir_tap_sequencer_coeff_bank.sv
// Coefficient register file: one synchronous write port, one combinational
// read port; every entry clears to 0 on reset.
module fir_coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TAP = NUM_TAP_DEF,
  parameter int unsigned COEFF_W = COEFF_W_DEF
) (
  input  logic                      iClk_12M,
  input  logic                      iRsn,
  input  logic                      iWrEn,
  input  logic [TAP_IDX_W-1:0]      iWrAddr,
  input  logic signed [COEFF_W-1:0] iWrData,
  input  logic [TAP_IDX_W-1:0]      iRdAddr,
  output logic signed [COEFF_W-1:0] oRdData
);

  localparam logic [TAP_IDX_W-1:0] TAP_NUM = TAP_IDX_W'(NUM_TAP);

  logic [NUM_TAP-1:0][COEFF_W-1:0] bank;

  // Writers guarantee iWrAddr < NUM_TAP whenever iWrEn is high.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      bank <= '0;
    end else if (iWrEn) begin
      bank[iWrAddr] <= iWrData;
    end
  end

  assign oRdData = (iRdAddr < TAP_NUM) ? $signed(bank[iRdAddr]) : '0;

endmodule : fir_coeff_bank

// File: rtl/fir_tap_sequencer.sv
// FIR MAC controller: divides iClk_12M down to the sample strobe, walks the
// tap MUL/ADD/ACC phases per sample and serves coefficients from a host bank.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned NUM_TAP = NUM_TAP_DEF,
  parameter int unsigned COEFF_W = COEFF_W_DEF
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnable,
  fir_tap_sequencer_if.slave         cfg,
  input  logic                       iClrStatus,
  output logic                       oEnSample_300k,
  output logic [TAP_IDX_W-1:0]       oEnMul,
  output logic                       oEnAdd,
  output logic                       oEnAcc,
  output logic signed [COEFF_W-1:0]  oCoeff,
  output logic                       oBusy,
  output logic                       oCfgErr,
  output logic                       oOverrun
);

  localparam int unsigned          CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [TAP_IDX_W-1:0] TAP_LAST = TAP_IDX_W'(NUM_TAP - 1);
  localparam logic [TAP_IDX_W-1:0] TAP_NUM  = TAP_IDX_W'(NUM_TAP);

  logic [CNT_W-1:0]          cnt;
  logic                      tick;
  state_t                    state;
  state_t                    stateNxt;
  logic [TAP_IDX_W-1:0]      tapNxt;
  logic                      cfgFire;
  logic                      cfgErrSet;
  logic                      wrEn;
  logic                      overrunSet;
  logic signed [COEFF_W-1:0] rdData;

  // Sample divider; parked at 0 while disabled so restart is phase-aligned.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      cnt <= '0;
    end else if (!iEnable || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = iEnable && (cnt == CNT_LAST);

  // Next state; oEnMul doubles as the tap counter and sits at 0 outside MUL.
  always_comb begin
    stateNxt = state;
    tapNxt   = '0;
    unique case (state)
      IDLE: if (tick) stateNxt = MUL;
      MUL: begin
        if (oEnMul == TAP_LAST) begin
          stateNxt = ADD;
        end else begin
          tapNxt = oEnMul + TAP_IDX_W'(1);
        end
      end
      ADD:     stateNxt = ACC;
      ACC:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Bank writes only while idle and no sample is about to start.
  assign cfg.oCfgReady = iRsn && (state == IDLE) && !tick;
  assign cfgFire       = cfg.iCfgValid && cfg.oCfgReady;
  assign cfgErrSet     = cfgFire && (cfg.iCfgAddr >= TAP_NUM);
  assign wrEn          = cfgFire && !cfgErrSet;
  assign overrunSet    = tick && (state != IDLE);

  fir_coeff_bank #(
    .NUM_TAP (NUM_TAP),
    .COEFF_W (COEFF_W)
  ) u_bank (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .iWrEn    (wrEn),
    .iWrAddr  (cfg.iCfgAddr),
    .iWrData  (cfg.iCfgData),
    .iRdAddr  (tapNxt),
    .oRdData  (rdData)
  );

  // Outputs track the upcoming state so they line up with the state register.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state          <= IDLE;
      oEnSample_300k <= 1'b0;
      oEnMul         <= '0;
      oEnAdd         <= 1'b0;
      oEnAcc         <= 1'b0;
      oCoeff         <= '0;
      oBusy          <= 1'b0;
      oCfgErr        <= 1'b0;
      oOverrun       <= 1'b0;
    end else begin
      state          <= stateNxt;
      oEnSample_300k <= tick;
      oEnMul         <= tapNxt;
      oEnAdd         <= (stateNxt == ADD);
      oEnAcc         <= (stateNxt == ACC);
      oCoeff         <= (stateNxt == MUL) ? rdData : '0;
      oBusy          <= (stateNxt != IDLE);
      oCfgErr        <= cfgErrSet  || (oCfgErr  && !iClrStatus);
      oOverrun       <= overrunSet || (oOverrun && !iClrStatus);
    end
  end

endmodule : fir_tap_sequencer

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: divider cadence, tap sequencing,
// gated coefficient writes, status flags, overrun and async reset.
module tb_fir_tap_sequencer;
  import fir_ctrl_pkg::*;

  localparam int unsigned NT = 10;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        en = 1'b0;
  logic        en8 = 1'b0;
  logic        clr = 1'b0;

  logic        strobe, enAdd, enAcc, busy, cfgErr, overrun;
  logic [3:0]  enMul;
  logic [15:0] coeff;
  logic        strobe8, enAdd8, enAcc8, busy8, cfgErr8, overrun8;
  logic [3:0]  enMul8;
  logic [15:0] coeff8;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [15:0] expCoeff [NT];

  fir_tap_sequencer_if #(.COEFF_W(16)) cfgIf ();
  fir_tap_sequencer_if #(.COEFF_W(16)) cfgIf8 ();

  fir_tap_sequencer #(.CLK_DIV(40), .NUM_TAP(10), .COEFF_W(16)) dut (
    .iClk_12M(clk), .iRsn(rstN), .iEnable(en), .cfg(cfgIf.slave), .iClrStatus(clr),
    .oEnSample_300k(strobe), .oEnMul(enMul), .oEnAdd(enAdd), .oEnAcc(enAcc),
    .oCoeff(coeff), .oBusy(busy), .oCfgErr(cfgErr), .oOverrun(overrun)
  );

  fir_tap_sequencer #(.CLK_DIV(8), .NUM_TAP(10), .COEFF_W(16)) dut8 (
    .iClk_12M(clk), .iRsn(rstN), .iEnable(en8), .cfg(cfgIf8.slave), .iClrStatus(clr),
    .oEnSample_300k(strobe8), .oEnMul(enMul8), .oEnAdd(enAdd8), .oEnAcc(enAcc8),
    .oCoeff(coeff8), .oBusy(busy8), .oCfgErr(cfgErr8), .oOverrun(overrun8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!strobe && n < 200);
    chk("strobe_timeout", 32'(strobe), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) step();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, output bit ok);
    ok = 1'b0;
    cfgIf.iCfgValid = 1'b1;
    cfgIf.iCfgAddr  = a;
    cfgIf.iCfgData  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      #3;
      ok = cfgIf.oCfgReady;
      @(posedge clk);
      #1;
    end
    cfgIf.iCfgValid = 1'b0;
  endtask

  // Entered in the strobe cycle; walks the whole sequence against expCoeff.
  task automatic run_sample(input string tag);
    for (int k = 0; k < int'(NT); k++) begin
      chk({tag, "_mul"}, 32'(enMul), 32'(k));
      chk({tag, "_coeff"}, 32'(coeff), 32'(expCoeff[k]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      step();
    end
    chk({tag, "_add"}, {31'd0, enAdd}, 32'd1);
    chk({tag, "_add_mul0"}, 32'(enMul), 32'd0);
    chk({tag, "_add_coeff0"}, 32'(coeff), 32'd0);
    step();
    chk({tag, "_acc"}, {31'd0, enAcc}, 32'd1);
    chk({tag, "_acc_add0"}, {31'd0, enAdd}, 32'd0);
    step();
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_acc0"}, {31'd0, enAcc}, 32'd0);
  endtask

  initial begin
    int n;
    bit ok;
    cfgIf.iCfgValid  = 1'b0;
    cfgIf.iCfgAddr   = '0;
    cfgIf.iCfgData   = '0;
    cfgIf8.iCfgValid = 1'b0;
    cfgIf8.iCfgAddr  = '0;
    cfgIf8.iCfgData  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", {31'd0, strobe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cfgIf.oCfgReady}, 32'd0);
    chk("rst_flags", {30'd0, cfgErr, overrun}, 32'd0);

    // Divider cadence: pulses at 40,80,...,200 cycles after release.
    rstN = 1'b1;
    en   = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      chk("div_strobe", {31'd0, strobe}, (k % 40 == 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    wait_idle();

    // Load bank[k] = k*100+1 while disabled.
    for (int k = 0; k < int'(NT); k++) begin
      expCoeff[k] = 16'(k * 100 + 1);
      cfg_write(4'(k), expCoeff[k], ok);
      chk("load_ack", {31'd0, ok}, 32'd1);
    end
    chk("load_err", {31'd0, cfgErr}, 32'd0);
    en = 1'b1;
    wait_strobe(n);
    chk("restart_gap", 32'(n), 32'd40);
    run_sample("seq1");

    // Write held across a running sample must wait for IDLE.
    wait_strobe(n);
    chk("gap_after_seq", 32'(n), 32'd28);
    cfgIf.iCfgValid = 1'b1;
    cfgIf.iCfgAddr  = 4'd3;
    cfgIf.iCfgData  = 16'h7FFF;
    for (int k = 0; k < int'(NT) + 2; k++) begin
      chk("hold_ready", {31'd0, cfgIf.oCfgReady}, 32'd0);
      if (k < int'(NT)) chk("hold_oldcoeff", 32'(coeff), 32'(expCoeff[k]));
      step();
    end
    chk("hold_idle_ready", {31'd0, cfgIf.oCfgReady}, 32'd1);
    step();
    cfgIf.iCfgValid = 1'b0;
    expCoeff[3] = 16'h7FFF;
    wait_strobe(n);
    run_sample("seq_new3");

    // Out-of-range write: accepted, flagged, bank untouched.
    cfg_write(4'd12, 16'h1234, ok);
    chk("bad_ack", {31'd0, ok}, 32'd1);
    chk("bad_err", {31'd0, cfgErr}, 32'd1);
    wait_strobe(n);
    run_sample("seq_bad");
    chk("err_sticky", {31'd0, cfgErr}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("err_clr", {31'd0, cfgErr}, 32'd0);
    clr = 1'b1;
    cfg_write(4'd15, 16'h0BAD, ok);
    clr = 1'b0;
    chk("err_set_wins", {31'd0, cfgErr}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("err_clr2", {31'd0, cfgErr}, 32'd0);
    chk("main_no_overrun", {31'd0, overrun}, 32'd0);

    // CLK_DIV=8 instance: second tick lands mid-sequence.
    en8 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!strobe8 && n < 50);
    chk("ov_first_gap", 32'(n), 32'd8);
    for (int i = 0; i < 12; i++) begin
      chk("ov_busy", {31'd0, busy8}, 32'd1);
      if (i < 10) chk("ov_mul", 32'(enMul8), 32'(i));
      if (i == 7) chk("ov_pre", {31'd0, overrun8}, 32'd0);
      if (i == 8) begin
        chk("ov_strobe2", {31'd0, strobe8}, 32'd1);
        chk("ov_set", {31'd0, overrun8}, 32'd1);
      end
      if (i == 10) chk("ov_add", {31'd0, enAdd8}, 32'd1);
      if (i == 11) chk("ov_acc", {31'd0, enAcc8}, 32'd1);
      step();
    end
    chk("ov_idle", {31'd0, busy8}, 32'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (!strobe8 && n < 50);
    chk("ov_next_gap", 32'(n), 32'd4);
    chk("ov_next_busy", {31'd0, busy8}, 32'd1);
    en8 = 1'b0;

    // Async reset mid-MUL.
    wait_strobe(n);
    repeat (5) step();
    chk("pre_rst_mul", 32'(enMul), 32'd5);
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_mul", 32'(enMul), 32'd0);
    chk("arst_coeff", 32'(coeff), 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, cfgIf.oCfgReady}, 32'd0);
    chk("arst_ov8", {31'd0, overrun8}, 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int k = 0; k < int'(NT); k++) expCoeff[k] = '0;
    wait_strobe(n);
    chk("post_rst_gap", 32'(n), 32'd40);
    run_sample("seq_zero");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule : tb_fir_tap_sequencer
